// File: rtl/bcd_sign_mag_recover_pkg.sv
// Shared definitions for the BCD sign/magnitude recovery back end.
// State encoding, digit limit and the nines-complement helper.
package bcd_sign_mag_recover_pkg;

    localparam logic [3:0] BCD_MAX = 4'd9;

    typedef enum logic [1:0] {
        ST_COLLECT = 2'd0,
        ST_CONV    = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    function automatic logic [3:0] nines(input logic [3:0] d);
        return BCD_MAX - d;
    endfunction

endpackage

// File: rtl/bcd_sign_mag_recover_digit_comp.sv
// One digit of the serial tens-complement, driven by the trailing-zero flag.
// Positive results (carry=1) pass straight through.
module bcd_digit_comp
    import bcd_sign_mag_recover_pkg::*;
(
    input  logic [3:0] d,
    input  logic       nz,
    input  logic       carry,
    output logic [3:0] digit,
    output logic       nz_next
);

    always_comb begin
        digit   = d;
        nz_next = nz;
        if (!carry) begin
            if (nz) begin
                digit = nines(d);
            end else if (d != 4'd0) begin
                digit   = nines(d) + 4'd1;
                nz_next = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bcd_sign_mag_recover.sv
// Collects a digit-serial raw BCD difference and recovers sign and magnitude.
// A single complement cell is stepped across the buffer, LSD first.
module bcd_sign_mag_recover
    import bcd_sign_mag_recover_pkg::*;
#(
    parameter int NDIG = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_digit,
    input  logic              in_last,
    input  logic              in_carry,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [4*NDIG-1:0] out_mag,
    output logic              out_neg,
    output logic              out_err
);

    localparam int CW = $clog2(NDIG);
    localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

    state_t        state;
    logic [CW-1:0] cnt;
    logic [3:0]    buf_q [NDIG];
    logic          carry_q;
    logic          nz_q;
    logic [3:0]    cdig;
    logic          cnz;
    logic          take;
    logic          last_idx;
    logic          bad_dig;

    bcd_digit_comp u_comp (
        .d       (buf_q[cnt]),
        .nz      (nz_q),
        .carry   (carry_q),
        .digit   (cdig),
        .nz_next (cnz)
    );

    assign in_ready = (state == ST_COLLECT);
    assign take     = in_valid && in_ready;
    assign last_idx = (cnt == LAST);
    assign bad_dig  = (in_digit > BCD_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_COLLECT;
            cnt       <= '0;
            buf_q     <= '{default: '0};
            carry_q   <= 1'b0;
            nz_q      <= 1'b0;
            out_valid <= 1'b0;
            out_mag   <= '0;
            out_neg   <= 1'b0;
            out_err   <= 1'b0;
        end else begin
            case (state)
                ST_COLLECT: begin
                    if (take) begin
                        buf_q[cnt] <= bad_dig ? 4'd0 : in_digit;
                        // frame length is fixed; a misplaced in_last only flags
                        if (bad_dig || (in_last != last_idx)) begin
                            out_err <= 1'b1;
                        end
                        if (last_idx) begin
                            carry_q <= in_carry;
                            nz_q    <= 1'b0;
                            cnt     <= '0;
                            state   <= ST_CONV;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                ST_CONV: begin
                    out_mag[{cnt, 2'b00} +: 4] <= cdig;
                    nz_q <= cnz;
                    if (last_idx) begin
                        cnt   <= '0;
                        state <= ST_DONE;
                        // no trailing nonzero digit on a negative: refuse -0
                        if (!carry_q && !cnz) begin
                            out_neg <= 1'b0;
                            out_err <= 1'b1;
                        end else begin
                            out_neg <= !carry_q;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        out_err   <= 1'b0;
                        state     <= ST_COLLECT;
                    end
                end
                default: state <= ST_COLLECT;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_sign_mag_recover.sv
// Bench for bcd_sign_mag_recover: directed table, corner sequences,
// and random frames against an arithmetic reference model.
module tb_bcd_sign_mag_recover;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_digit;
    logic        in_last;
    logic        in_carry;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_mag;
    logic        out_neg;
    logic        out_err;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    bcd_sign_mag_recover #(.NDIG(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_digit  (in_digit),
        .in_last   (in_last),
        .in_carry  (in_carry),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_mag   (out_mag),
        .out_neg   (out_neg),
        .out_err   (out_err)
    );

    typedef struct {
        logic [15:0] raw;
        logic [3:0]  lastm;
        logic        carry;
        logic [15:0] mag;
        logic        neg;
        logic        err;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the decimal value.
    function automatic vec_t model(input logic [15:0] raw,
                                   input logic [3:0] lm, input logic c);
        vec_t v;
        int r = 0;
        int p = 1;
        int m;
        int dg;
        v.raw = raw;
        v.lastm = lm;
        v.carry = c;
        v.err = (lm != 4'b1000);
        for (int i = 0; i < 4; i++) begin
            dg = int'(raw[4*i +: 4]);
            if (dg > 9) begin
                v.err = 1'b1;
                dg = 0;
            end
            r += dg * p;
            p *= 10;
        end
        v.neg = 1'b0;
        if (c) begin
            m = r;
        end else if (r == 0) begin
            m = 0;
            v.err = 1'b1;
        end else begin
            m = 10000 - r;
            v.neg = 1'b1;
        end
        v.mag = '0;
        for (int i = 0; i < 4; i++) begin
            v.mag[4*i +: 4] = 4'(m % 10);
            m = m / 10;
        end
        return v;
    endfunction

    task automatic send_frame(input logic [15:0] raw, input logic [3:0] lm,
                              input logic c, input bit gaps);
        bit ok;
        bit rdy;
        int n;
        for (int i = 0; i < 4; i++) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                in_valid = 1'b0;
                @(posedge clk);
                #1;
            end
            in_valid = 1'b1;
            in_digit = raw[4*i +: 4];
            in_last  = lm[i];
            in_carry = (i == 3) ? c : ~c;
            ok = 1'b0;
            n = 0;
            while (!ok && n < 50) begin
                @(negedge clk);
                rdy = in_ready;
                @(posedge clk);
                #1;
                n++;
                ok = rdy;
            end
            if (!ok) chk("accept_timeout", 0, 1);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!out_valid) chk("valid_timeout", 0, 1);
    endtask

    task automatic check_out(input string nm, input vec_t v);
        chk({nm, "_mag"}, 32'(out_mag), 32'(v.mag));
        chk({nm, "_neg"}, 32'(out_neg), 32'(v.neg));
        chk({nm, "_err"}, 32'(out_err), 32'(v.err));
    endtask

    task automatic handshake(input string nm);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk({nm, "_valid_drop"}, 32'(out_valid), 0);
        chk({nm, "_ready_back"}, 32'(in_ready), 1);
    endtask

    task automatic run_frame(input string nm, input vec_t v, input bit gaps,
                             input bit chk_lat);
        int lat;
        send_frame(v.raw, v.lastm, v.carry, gaps);
        wait_valid(lat);
        if (chk_lat) chk({nm, "_latency"}, 32'(lat), 5);
        check_out(nm, v);
        handshake(nm);
    endtask

    vec_t tbl[9];
    vec_t v;
    vec_t v2;
    int lat;
    logic [15:0] hold;

    initial begin
        tbl[0] = '{16'h0431, 4'b1000, 1'b1, 16'h0431, 1'b0, 1'b0};
        tbl[1] = '{16'h9569, 4'b1000, 1'b0, 16'h0431, 1'b1, 1'b0};
        tbl[2] = '{16'h9500, 4'b1000, 1'b0, 16'h0500, 1'b1, 1'b0};
        tbl[3] = '{16'h0B31, 4'b1000, 1'b1, 16'h0031, 1'b0, 1'b1};
        tbl[4] = '{16'h0431, 4'b1010, 1'b1, 16'h0431, 1'b0, 1'b1};
        tbl[5] = '{16'h0000, 4'b1000, 1'b0, 16'h0000, 1'b0, 1'b1};
        tbl[6] = '{16'h0431, 4'b0000, 1'b1, 16'h0431, 1'b0, 1'b1};
        tbl[7] = '{16'h0001, 4'b1000, 1'b0, 16'h9999, 1'b1, 1'b0};
        tbl[8] = '{16'h9999, 4'b1000, 1'b1, 16'h9999, 1'b0, 1'b0};

        rst = 1'b1;
        in_valid = 1'b0;
        in_digit = '0;
        in_last = 1'b0;
        in_carry = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_mag", 32'(out_mag), 0);
        chk("rst_neg", 32'(out_neg), 0);
        chk("rst_err", 32'(out_err), 0);
        chk("rst_ready", 32'(in_ready), 1);
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 9; i++) begin
            run_frame($sformatf("tbl%0d", i), tbl[i], 1'b0, 1'b1);
        end

        // back-pressure with in_valid toggling
        send_frame(16'h9569, 4'b1000, 1'b0, 1'b0);
        wait_valid(lat);
        hold = out_mag;
        for (int k = 0; k < 5; k++) begin
            in_valid = k[0];
            in_digit = 4'h7;
            in_last  = 1'b1;
            @(posedge clk);
            #1;
            chk("bp_mag", 32'(out_mag), 32'(hold));
            chk("bp_valid", 32'(out_valid), 1);
            chk("bp_ready", 32'(in_ready), 0);
        end
        check_out("bp", tbl[1]);
        in_valid = 1'b1;
        in_digit = 4'h5;
        in_last  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        chk("bp_valid_drop", 32'(out_valid), 0);
        chk("bp_ready_back", 32'(in_ready), 1);
        run_frame("after_bp", tbl[2], 1'b0, 1'b1);

        // reset in the second conversion cycle
        send_frame(16'h9500, 4'b1000, 1'b1, 1'b0);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_valid", 32'(out_valid), 0);
        chk("midrst_ready", 32'(in_ready), 1);
        chk("midrst_err", 32'(out_err), 0);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        run_frame("after_rst", tbl[1], 1'b0, 1'b1);

        // reset mid-frame discards the partial digits
        in_valid = 1'b1;
        in_digit = 4'h3;
        in_last  = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        rst = 1'b1;
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;
        run_frame("after_rst2", tbl[0], 1'b0, 1'b1);

        for (int n = 0; n < 40; n++) begin
            logic [15:0] raw;
            logic [3:0] lm;
            for (int i = 0; i < 4; i++) begin
                raw[4*i +: 4] = ($urandom_range(0, 15) == 0)
                    ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
            end
            if (n % 5 == 0) raw[7:0] = 8'h00;
            lm = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'b1000;
            v2 = model(raw, lm, 1'($urandom));
            run_frame($sformatf("rnd%0d", n), v2, 1'b1, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
